hit_normal_pipeline: RTL

- Parametrised successor of the single-cycle plane-normal stage in the ray-hit shading path.
- Produces the unnormalised surface normal at a hit point for plane or sphere primitives, with an optional inward-facing flip.
- Adds a configurable pipeline depth, valid/ready backpressure and a pass-through tag.
- Sits between the intersection unit and the normaliser. Its output feeds the normaliser directly.

---
 rtl/hit_normal_pipeline.sv | 59 +++++
 1 files changed

// File: rtl/hit_normal_pipeline.sv
// hit_normal_pipeline: plane/sphere hit normal with optional flip, STAGES-deep valid/ready pipeline
module hit_normal_pipeline #(
  parameter int COORD_W = 32,
  parameter int STAGES = 1,
  parameter int TAG_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic                   in_flip,
  input  logic [3*COORD_W-1:0]   prim_param,
  input  logic [3*COORD_W-1:0]   hit_pos,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3*COORD_W-1:0]   hit_normal_unnormalized,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   busy
);
  localparam int VW = 3*COORD_W;
  logic [STAGES-1:0] v;
  logic [VW-1:0]     d [STAGES];
  logic [TAG_W-1:0]  t [STAGES];
  logic [VW-1:0]     n;
  logic              stall;
  for (genvar c = 0; c < 3; c++) begin : g_c
    logic [COORD_W-1:0] p, h, r;
    assign p = prim_param[c*COORD_W +: COORD_W];
    assign h = hit_pos[c*COORD_W +: COORD_W];
    assign r = in_mode ? h - p : p;
    assign n[c*COORD_W +: COORD_W] = in_flip ? -r : r;
  end
  assign stall = v[STAGES-1] & ~out_ready;
  assign in_ready = rst | ~stall;
  assign out_valid = v[STAGES-1];
  assign hit_normal_unnormalized = d[STAGES-1];
  assign out_tag = t[STAGES-1];
  assign busy = |v;
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= '0;
        t[i] <= '0;
      end
    end else if (!stall) begin
      v[0] <= in_valid;
      d[0] <= n;
      t[0] <= in_tag;
      for (int i = 1; i < STAGES; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
        t[i] <= t[i-1];
      end
    end
  end
endmodule
